// File: rtl/std_fp_accum_driver.sv
// -----------------------------------------------------------------------------
// std_fp_accum_driver
//
// Sums N floating-point elements read from a small combinational memory by
// driving an external go/done FP adder one operation at a time. The running
// sum (acc) is fed back as the left operand. The memory element is the right
// operand. One idle cycle (GAP) separates adder operations so the adder's
// done pipeline clears.
//
// Optional feature (compile-time macro):
//   FP_ACCUM_FLAGS_EN - when defined, the adder exception flags are OR-ed
//                       into a sticky flag register across the run. When
//                       undefined, the register is absent and flags is 0.
//                       Sum behaviour and timing are the same either way.
//
// Parameters:
//   WIDTH   operand/result width in bits
//   ADDR_W  element-memory address width (N ranges 0..2^ADDR_W)
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous, active-high reset
//   go             start; held high by the parent until done is seen.
//                  Dropping it mid-run aborts to IDLE.
//   len            element count N, sampled at start and clamped to 2^ADDR_W
//   mem_addr       element read address
//   mem_read_data  element at mem_addr, same cycle
//   add_go         request to the FP adder
//   add_left       adder left operand (running sum)
//   add_right      adder right operand (current element)
//   add_sub        adder subtract select, always 0
//   add_out        adder result
//   add_flags      adder exception flags
//   add_done       adder completion; ignored outside ISSUE
//   sum            accumulated result (mirrors acc at all times)
//   flags          accumulated exception flags
//   done           one-cycle completion pulse
// -----------------------------------------------------------------------------
module std_fp_accum_driver #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_read_data,
  output logic              add_go,
  output logic [WIDTH-1:0]  add_left,
  output logic [WIDTH-1:0]  add_right,
  output logic              add_sub,
  input  logic [WIDTH-1:0]  add_out,
  input  logic [4:0]        add_flags,
  input  logic              add_done,
  output logic [WIDTH-1:0]  sum,
  output logic [4:0]        flags,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_FIN
  } state_e;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [ADDR_W:0]   len_clamped;
  logic              idx_last;

  // Lengths above the memory depth are treated as a full memory.
  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  // Only evaluated in ISSUE, where N is known to be nonzero.
  assign idx_last    = (idx_q == (n_q - IDX_ONE));

`ifdef FP_ACCUM_FLAGS_EN
  logic [4:0] flg_q, flg_d;
`else
  logic unused_add_flags;
  assign unused_add_flags = ^add_flags;
`endif

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    acc_d   = acc_q;
`ifdef FP_ACCUM_FLAGS_EN
    flg_d   = flg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (go) begin
          // Every run starts from +0.0 so an empty run reports a zero sum.
          n_d   = len_clamped;
          idx_d = '0;
          acc_d = '0;
`ifdef FP_ACCUM_FLAGS_EN
          flg_d = '0;
`endif
          state_d = (len_clamped == '0) ? S_FIN : S_ISSUE;
        end
      end

      S_ISSUE: begin
        // An abort wins over a completing add; acc keeps its partial value.
        if (!go) begin
          state_d = S_IDLE;
        end else if (add_done) begin
          acc_d   = add_out;
          idx_d   = idx_q + IDX_ONE;
`ifdef FP_ACCUM_FLAGS_EN
          flg_d   = flg_q | add_flags;
`endif
          state_d = idx_last ? S_FIN : S_GAP;
        end
      end

      S_GAP: begin
        state_d = go ? S_ISSUE : S_IDLE;
      end

      S_FIN: begin
        // Always return to IDLE; a restart needs go high while in IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
    end
  end

`ifdef FP_ACCUM_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      flg_q <= '0;
    end else begin
      flg_q <= flg_d;
    end
  end
  assign flags = flg_q;
`else
  assign flags = 5'b0;
`endif

  // Operands come straight from registered state and the memory, so they
  // stay stable for the whole ISSUE window while the adder works.
  assign add_go    = (state_q == S_ISSUE);
  assign mem_addr  = idx_q[ADDR_W-1:0];
  assign add_left  = acc_q;
  assign add_right = mem_read_data;
  assign add_sub   = 1'b0;
  assign sum       = acc_q;
  assign done      = (state_q == S_FIN);

endmodule
